// File: rtl/bytecode_fetch_if.sv
// Program-memory port between the fetch unit and the byte-wide ROM.
// Read data is valid in the cycle after the edge that samples mem_re.
interface bytecode_fetch_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_re;
   logic [7:0]            mem_rdata;

   modport master (
      output mem_addr,
      output mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/bytecode_fetch.sv
// Fetches opcode/arg bytes and big-endian data words from program ROM
// on behalf of the CPU, exposing only complete, current groups.
module bytecode_fetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 16'h8000,
   parameter logic [7:0]            NOP_CODE   = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] program_counter,
   input  logic [15:0]           dataindex,
   bytecode_fetch_if.master      mem,
   output logic [7:0]            op_code,
   output logic [7:0]            arg1,
   output logic [7:0]            arg2,
   output logic [31:0]           dataparams,
   output logic                  instr_valid,
   output logic                  data_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_IFETCH,
      S_DFETCH
   } state_t;

   state_t                r_state, w_state_n;
   logic [ADDR_WIDTH-1:0] r_fpc, w_fpc_n;
   logic [15:0]           r_fdi, w_fdi_n;
   logic [15:0]           r_fdi_old, w_fdi_old_n;
   logic                  r_ifl, w_ifl_n;
   logic                  r_dfl, w_dfl_n;
   logic [2:0]            r_cnt, w_cnt_n;
   logic                  r_tag_v, w_tag_v_n;
   logic [2:0]            r_tag_idx, w_tag_idx_n;
   logic [2:0][7:0]       r_sh, w_sh_n;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
   logic                  r_re, w_re_n;
   logic [7:0]            r_op, w_op_n;
   logic [7:0]            r_a1, w_a1_n;
   logic [7:0]            r_a2, w_a2_n;
   logic [31:0]           r_dp, w_dp_n;
   logic                  r_iv, w_iv_n;
   logic                  r_dv, w_dv_n;

   logic                  w_ipend;
   logic                  w_dpend;
   logic [ADDR_WIDTH-1:0] w_dbase;
   logic [2:0]            w_last;
   logic                  w_fin;
   logic                  w_free;
   logic                  w_step;

   always_comb begin
      w_ipend     = (program_counter != r_fpc) || r_ifl;
      w_dpend     = (dataindex != r_fdi) || r_dfl;
      w_dbase     = DATA_BASE + ADDR_WIDTH'({dataindex, 2'b00});
      w_last      = (r_state == S_DFETCH) ? 3'd3 : 3'd2;
      w_fin       = r_tag_v && (r_tag_idx == w_last);
      w_free      = 1'b0;
      w_step      = 1'b0;
      w_state_n   = r_state;
      w_fpc_n     = r_fpc;
      w_fdi_n     = r_fdi;
      w_fdi_old_n = r_fdi_old;
      w_ifl_n     = r_ifl;
      w_dfl_n     = r_dfl;
      w_cnt_n     = r_cnt;
      w_sh_n      = r_sh;
      w_addr_n    = r_addr;
      w_re_n      = r_re;
      w_op_n      = r_op;
      w_a1_n      = r_a1;
      w_a2_n      = r_a2;
      w_dp_n      = r_dp;
      w_iv_n      = r_iv;
      w_dv_n      = r_dv;
      // a tag follows each issued address to the cycle its byte returns
      w_tag_v_n   = r_re;
      w_tag_idx_n = r_cnt;

      if (w_ipend) begin
         w_iv_n = 1'b0;
         w_op_n = NOP_CODE;
      end
      if (w_dpend)
         w_dv_n = 1'b0;

      unique case (r_state)
         S_IDLE: w_free = 1'b1;
         S_IFETCH: begin
            if (program_counter != r_fpc) begin
               w_state_n = S_IDLE;
               w_re_n    = 1'b0;
               w_tag_v_n = 1'b0;
            end else if (w_fin) begin
               w_op_n = r_sh[0];
               w_a1_n = r_sh[1];
               w_a2_n = mem.mem_rdata;
               w_iv_n = 1'b1;
               w_free = 1'b1;
            end else begin
               w_step = 1'b1;
            end
         end
         S_DFETCH: begin
            if (w_ipend) begin
               w_state_n = S_IDLE;
               w_re_n    = 1'b0;
               w_tag_v_n = 1'b0;
               w_fdi_n   = r_fdi_old;
            end else if (dataindex != r_fdi) begin
               w_state_n = S_IDLE;
               w_re_n    = 1'b0;
               w_tag_v_n = 1'b0;
            end else if (w_fin) begin
               w_dp_n    = {r_sh[0], r_sh[1], r_sh[2], mem.mem_rdata};
               w_dv_n    = 1'b1;
               w_dfl_n   = 1'b0;
               w_state_n = S_IDLE;
               w_re_n    = 1'b0;
            end else begin
               w_step = 1'b1;
            end
         end
         default: w_state_n = S_IDLE;
      endcase

      if (w_step) begin
         if (r_tag_v)
            w_sh_n[r_tag_idx[1:0]] = mem.mem_rdata;
         if (r_re && (r_cnt != w_last)) begin
            w_addr_n = r_addr + ADDR_WIDTH'(1);
            w_cnt_n  = r_cnt + 3'd1;
         end else begin
            w_re_n = 1'b0;
         end
      end

      // a finished fetch hands straight over to the next pending one
      if (w_free) begin
         if (w_ipend) begin
            w_fpc_n   = program_counter;
            w_ifl_n   = 1'b0;
            w_cnt_n   = 3'd0;
            w_addr_n  = program_counter;
            w_re_n    = 1'b1;
            w_state_n = S_IFETCH;
         end else if (w_dpend) begin
            w_fdi_old_n = r_fdi;
            w_fdi_n     = dataindex;
            w_cnt_n     = 3'd0;
            w_addr_n    = w_dbase;
            w_re_n      = 1'b1;
            w_state_n   = S_DFETCH;
         end else begin
            w_re_n    = 1'b0;
            w_state_n = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_fpc     <= '0;
         r_fdi     <= '0;
         r_fdi_old <= '0;
         r_ifl     <= 1'b1;
         r_dfl     <= 1'b1;
         r_cnt     <= '0;
         r_tag_v   <= 1'b0;
         r_tag_idx <= '0;
         r_sh      <= '0;
         r_addr    <= '0;
         r_re      <= 1'b0;
         r_op      <= NOP_CODE;
         r_a1      <= '0;
         r_a2      <= '0;
         r_dp      <= '0;
         r_iv      <= 1'b0;
         r_dv      <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_fpc     <= w_fpc_n;
         r_fdi     <= w_fdi_n;
         r_fdi_old <= w_fdi_old_n;
         r_ifl     <= w_ifl_n;
         r_dfl     <= w_dfl_n;
         r_cnt     <= w_cnt_n;
         r_tag_v   <= w_tag_v_n;
         r_tag_idx <= w_tag_idx_n;
         r_sh      <= w_sh_n;
         r_addr    <= w_addr_n;
         r_re      <= w_re_n;
         r_op      <= w_op_n;
         r_a1      <= w_a1_n;
         r_a2      <= w_a2_n;
         r_dp      <= w_dp_n;
         r_iv      <= w_iv_n;
         r_dv      <= w_dv_n;
      end
   end

   assign mem.mem_addr = r_addr;
   assign mem.mem_re   = r_re;
   assign op_code      = r_op;
   assign arg1         = r_a1;
   assign arg2         = r_a2;
   assign dataparams   = r_dp;
   assign instr_valid  = r_iv;
   assign data_valid   = r_dv;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Randomised bench for bytecode_fetch: ROM model, fetch reference
// model, and directed scenarios for latency, wrap and abort cases.
module tb_bytecode_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pc  = '0;
   logic [15:0] di  = '0;
   logic [7:0]  op_code, arg1, arg2;
   logic [31:0] dataparams;
   logic        instr_valid, data_valid;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   logic [7:0] rom [65536];

   bytecode_fetch_if #(.ADDR_WIDTH(16)) bus ();

   bytecode_fetch #(
      .ADDR_WIDTH(16),
      .DATA_BASE (16'h8000),
      .NOP_CODE  (8'h00)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .program_counter(pc),
      .dataindex      (di),
      .mem            (bus.master),
      .op_code        (op_code),
      .arg1           (arg1),
      .arg2           (arg2),
      .dataparams     (dataparams),
      .instr_valid    (instr_valid),
      .data_valid     (data_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.mem_re) bus.mem_rdata <= rom[bus.mem_addr];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dword(input logic [15:0] idx);
      logic [15:0] b0, b1, b2, b3;
      b0 = 16'h8000 + {idx[13:0], 2'b00};
      b1 = b0 + 16'd1;
      b2 = b0 + 16'd2;
      b3 = b0 + 16'd3;
      return {rom[b0], rom[b1], rom[b2], rom[b3]};
   endfunction

   // reference model: a fetch is a timed job that either survives its
   // full latency with unchanged inputs or is dropped
   int          m_busy = 0;
   int          m_t = 0;
   logic [15:0] m_fpc = '0, m_fdi = '0, m_fdi_prev = '0;
   bit          m_if = 1'b1, m_df = 1'b1;
   bit          ip, dp, free;
   logic [15:0] a1a, a2a;
   logic [7:0]  e_op = 8'h00, e_a1 = '0, e_a2 = '0;
   logic [31:0] e_dp = '0;
   bit          e_iv = 1'b0, e_dv = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 0; m_t = 0;
         m_fpc = '0; m_fdi = '0; m_fdi_prev = '0;
         m_if = 1'b1; m_df = 1'b1;
         e_op = 8'h00; e_a1 = '0; e_a2 = '0; e_dp = '0;
         e_iv = 1'b0; e_dv = 1'b0;
      end else begin
         ip = (pc != m_fpc) || m_if;
         dp = (di != m_fdi) || m_df;
         if (ip) begin e_iv = 1'b0; e_op = 8'h00; end
         if (dp) e_dv = 1'b0;
         free = 1'b0;
         case (m_busy)
            0: free = 1'b1;
            1: begin
               m_t++;
               if (pc != m_fpc) m_busy = 0;
               else if (m_t == 4) begin
                  a1a = m_fpc + 16'd1;
                  a2a = m_fpc + 16'd2;
                  e_op = rom[m_fpc]; e_a1 = rom[a1a]; e_a2 = rom[a2a];
                  e_iv = 1'b1; m_busy = 0; free = 1'b1;
               end
            end
            default: begin
               m_t++;
               if (ip) begin m_busy = 0; m_fdi = m_fdi_prev; end
               else if (di != m_fdi) m_busy = 0;
               else if (m_t == 5) begin
                  e_dp = dword(m_fdi); e_dv = 1'b1;
                  m_df = 1'b0; m_busy = 0;
               end
            end
         endcase
         if (free) begin
            if ((pc != m_fpc) || m_if) begin
               m_fpc = pc; m_if = 1'b0; m_busy = 1; m_t = 0;
            end else if ((di != m_fdi) || m_df) begin
               m_fdi_prev = m_fdi; m_fdi = di; m_busy = 2; m_t = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst && chk_on) begin
         chk("m_op", {24'd0, op_code}, {24'd0, e_op});
         chk("m_arg1", {24'd0, arg1}, {24'd0, e_a1});
         chk("m_arg2", {24'd0, arg2}, {24'd0, e_a2});
         chk("m_data", dataparams, e_dp);
         chk("m_iv", {31'd0, instr_valid}, {31'd0, e_iv});
         chk("m_dv", {31'd0, data_valid}, {31'd0, e_dv});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst_vals(input string tag);
      chk({tag, "_op"}, {24'd0, op_code}, 32'h0);
      chk({tag, "_a1"}, {24'd0, arg1}, 32'h0);
      chk({tag, "_dp"}, dataparams, 32'h0);
      chk({tag, "_iv"}, {31'd0, instr_valid}, 32'h0);
      chk({tag, "_dv"}, {31'd0, data_valid}, 32'h0);
      chk({tag, "_re"}, {31'd0, bus.mem_re}, 32'h0);
      chk({tag, "_addr"}, {16'd0, bus.mem_addr}, 32'h0);
   endtask

   logic [31:0] old_dp;

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
      rom[16'h0000] = 8'hB8; rom[16'h0001] = 8'h00; rom[16'h0002] = 8'h01;
      rom[16'h800C] = 8'h12; rom[16'h800D] = 8'h34;
      rom[16'h800E] = 8'h56; rom[16'h800F] = 8'h78;
      chk_on = 1'b1;

      // reset release with program_counter 0
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_rst_vals("rst");
      #1 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("boot_iv", {31'd0, instr_valid}, 32'h0);
         chk("boot_op", {24'd0, op_code}, 32'h0);
      end
      tick();
      chk("boot_op", {24'd0, op_code}, 32'hB8);
      chk("boot_a1", {24'd0, arg1}, 32'h00);
      chk("boot_a2", {24'd0, arg2}, 32'h01);
      chk("boot_iv", {31'd0, instr_valid}, 32'h1);
      repeat (4) tick();
      chk("boot_dv0", {31'd0, data_valid}, 32'h0);
      tick();
      chk("boot_dv", {31'd0, data_valid}, 32'h1);
      chk("boot_dp", dataparams, dword(16'd0));

      // dataindex 0 -> 3
      old_dp = dataparams;
      di = 16'd3;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("di3_dv0", {31'd0, data_valid}, 32'h0);
         chk("di3_hold", dataparams, old_dp);
      end
      tick();
      chk("di3_dv", {31'd0, data_valid}, 32'h1);
      chk("di3_dp", dataparams, 32'h12345678);

      // program_counter wrap at FFFF
      rom[16'hFFFF] = 8'h10; rom[16'h0000] = 8'h20; rom[16'h0001] = 8'h30;
      pc = 16'hFFFF;
      repeat (5) tick();
      chk("wrap_op", {24'd0, op_code}, 32'h10);
      chk("wrap_a1", {24'd0, arg1}, 32'h20);
      chk("wrap_a2", {24'd0, arg2}, 32'h30);
      chk("wrap_iv", {31'd0, instr_valid}, 32'h1);

      // program_counter 0 -> 5 during the second fetch cycle
      pc = 16'h0000;
      tick();
      tick();
      pc = 16'h0005;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("abt_iv0", {31'd0, instr_valid}, 32'h0);
      end
      tick();
      chk("abt_iv", {31'd0, instr_valid}, 32'h1);
      chk("abt_op", {24'd0, op_code}, {24'd0, rom[16'h0005]});
      chk("abt_a1", {24'd0, arg1}, {24'd0, rom[16'h0006]});
      chk("abt_a2", {24'd0, arg2}, {24'd0, rom[16'h0007]});

      // simultaneous program_counter and dataindex change
      pc = 16'h0040;
      di = 16'd7;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("sim_op_nop", {24'd0, op_code}, 32'h0);
         chk("sim_iv0", {31'd0, instr_valid}, 32'h0);
      end
      tick();
      chk("sim_iv", {31'd0, instr_valid}, 32'h1);
      chk("sim_op", {24'd0, op_code}, {24'd0, rom[16'h0040]});
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("sim_dv0", {31'd0, data_valid}, 32'h0);
      end
      tick();
      chk("sim_dv", {31'd0, data_valid}, 32'h1);
      chk("sim_dp", dataparams, dword(16'd7));

      // reset asserted in the middle of a data fetch
      di = 16'd9;
      repeat (3) tick();
      #2 rst = 1'b0;
      #1 chk_rst_vals("amid");
      @(negedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_iv0", {31'd0, instr_valid}, 32'h0);
      end
      tick();
      chk("rr_iv", {31'd0, instr_valid}, 32'h1);
      chk("rr_op", {24'd0, op_code}, {24'd0, rom[16'h0040]});
      repeat (4) tick();
      chk("rr_dv0", {31'd0, data_valid}, 32'h0);
      tick();
      chk("rr_dv", {31'd0, data_valid}, 32'h1);
      chk("rr_dp", dataparams, dword(16'd9));

      // random traffic against the reference model
      for (int it = 0; it < 500; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               if ($urandom_range(0, 3) == 0)
                  pc = 16'hFFFD + 16'($urandom_range(0, 2));
               else
                  pc = 16'($urandom);
            end
            4, 5, 6: di = 16'($urandom);
            7: begin
               pc = 16'($urandom);
               di = 16'($urandom);
            end
            8: ;
            default: begin
               if ($urandom_range(0, 9) == 0) begin
                  @(posedge clk);
                  #3 rst = 1'b0;
                  #1 chk("rnd_rst_op", {24'd0, op_code}, 32'h0);
                  chk("rnd_rst_dv", {31'd0, data_valid}, 32'h0);
                  @(negedge clk);
                  #1 rst = 1'b1;
               end
            end
         endcase
         repeat ($urandom_range(1, 8)) tick();
      end
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
